// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder.
// Holds the feeder state encoding and the element slice helper.
// No logic, no latency, no backpressure of its own.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feed_state_t;

  // LSB position of element `row` inside a packed vector of `width`-bit elements.
  function automatic int lane_lsb(input int row, input int width);
    return row * width;
  endfunction

endpackage

// File: rtl/act_vec_fifo.sv
// Synchronous vector FIFO with occupancy count and wrap-around pointers.
// Latency: a write is visible on o_rdat (show-ahead) the cycle after it is written.
// Backpressure: caller must not push when o_count == DEPTH nor pop when empty.
module act_vec_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdat,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdat  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/systolic_act_feeder.sv
// Buffers activation vectors and injects each tile into the PE array with diagonal skew.
// Latency: push at t -> CLEAR at t+1, first pop at t+2, row r output at pop+1+r.
// Backpressure: in_ready drops while the FIFO is full; the array side never stalls.
module systolic_act_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 4,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic [ROWS*DATA_WIDTH-1:0] act_out,
  output logic [ROWS-1:0]            acc_en,
  output logic                       clear_acc,
  output logic                       tile_done,
  output logic                       busy
);

  localparam int VW    = ROWS * DATA_WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(ROWS) + 1;

  feed_state_t      r_state;
  feed_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0] w_drain_cnt_nxt;
  logic             r_tile_done;
  logic             w_tile_done_nxt;
  logic [CW-1:0]    w_count;
  logic [VW:0]      w_fifo_rdat;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;

  assign in_ready = (w_count < CW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_empty  = (w_count == '0);

  act_vec_fifo #(
    .WIDTH (VW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdat  ({in_last, in_data}),
    .i_pop   (w_pop),
    .o_rdat  (w_fifo_rdat),
    .o_count (w_count)
  );

  // State, drain counter and the registered tile_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
      r_tile_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_tile_done <= w_tile_done_nxt;
    end
  end

  // Next state and pop decision. IDLE also reacts to a push in flight so that
  // CLEAR lands in the same cycle the pushed entry becomes visible.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_pop           = 1'b0;
    w_tile_done_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty || w_push) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        w_state_nxt = STREAM;
      end
      STREAM: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_fifo_rdat[VW]) begin
            w_state_nxt     = DRAIN;
            w_drain_cnt_nxt = CNT_W'(ROWS - 1);
          end
        end
      end
      DRAIN: begin
        w_drain_cnt_nxt = r_drain_cnt - CNT_W'(1);
        if (r_drain_cnt == CNT_W'(1)) begin
          w_tile_done_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign clear_acc = (r_state == CLEAR);
  assign busy      = (r_state != IDLE);
  assign tile_done = r_tile_done;

  // Row r owns a chain of r+1 flops: stage 0 is the pop register, stage r drives the array.
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    logic [DATA_WIDTH-1:0] r_dat [g+1];
    logic [g:0]            r_vld;

    // Empty slots shift zero data with valid low, exactly like a real element.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= '0;
        for (int k = 0; k <= g; k++) r_dat[k] <= '0;
      end else begin
        r_dat[0] <= w_pop ? w_fifo_rdat[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH] : '0;
        r_vld[0] <= w_pop;
        for (int k = 1; k <= g; k++) begin
          r_dat[k] <= r_dat[k-1];
          r_vld[k] <= r_vld[k-1];
        end
      end
    end

    assign act_out[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH] = r_dat[g];
    assign acc_en[g] = r_vld[g];
  end

endmodule
